// File: rtl/av2_tile_bitstream_feeder.sv
// av2_tile_bitstream_feeder
//
// Source end of the tile bitstream interface. It fetches a tile's compressed
// bytes one at a time from byte-wide bitstream memory, packs them into
// 128-bit words and hands them to the tile decoder over a valid/ready
// handshake through a small word FIFO. The final word carries tile_last, and
// done pulses once that word has been accepted.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse: latch base/size and begin (ignored while busy)
//   tile_base_addr   byte address of the first tile byte
//   tile_size_bytes  tile length in bytes
//   mem_rd_en        byte read strobe
//   mem_rd_addr      byte read address
//   mem_rd_data      read data, valid exactly one cycle after mem_rd_en
//   tile_data        packed word, byte k in bits [8k+7:8k]
//   tile_valid       FIFO head is valid
//   tile_ready       decoder accepts the head when valid & ready
//   tile_last        head is the final word of the tile
//   busy             transfer in progress
//   done             one-cycle pulse after the last word is accepted
//   words_sent       words accepted in the current tile
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start
// FETCH | issuing up to 16 byte reads and capturing them into the pack reg
// PUSH  | pack register complete; waiting for FIFO space to push it
// DRAIN | all words pushed; waiting for the decoder to empty the FIFO

module av2_tile_bitstream_feeder #(
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE_WIDTH = 24,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] tile_base_addr,
    input  logic [SIZE_WIDTH-1:0] tile_size_bytes,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [7:0]            mem_rd_data,
    output logic [127:0]          tile_data,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic                  tile_last,
    output logic                  busy,
    output logic                  done,
    output logic [SIZE_WIDTH-5:0] words_sent
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PUSH  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [SIZE_WIDTH-1:0] size_q;
    logic [SIZE_WIDTH-1:0] byte_idx;      // index of the next byte to read
    logic [4:0]            issue_left;    // reads still to issue for this word
    logic                  rd_pend;       // a read was issued last cycle
    logic                  rd_final;      // that read is the last byte of the word
    logic [3:0]            rd_lane;
    logic [127:0]          pack_q;
    logic                  done_q;
    logic [SIZE_WIDTH-5:0] words_sent_q;

    logic [128:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic [PTR_W:0]        fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push;
    logic                  start_ok;
    logic                  more_bytes;
    logic                  drain_done;
    logic [SIZE_WIDTH-1:0] bytes_left;
    logic [128:0]          head;

    function automatic logic [4:0] min16(input logic [SIZE_WIDTH-1:0] n);
        return (n > SIZE_WIDTH'(16)) ? 5'd16 : n[4:0];
    endfunction

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = !fifo_empty && tile_ready;
    assign start_ok   = (state == IDLE) && start;
    assign bytes_left = size_q - byte_idx;
    assign more_bytes = (byte_idx != size_q);
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (tile_size_bytes == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                // Leave only once the final byte of the word is being captured.
                if (rd_pend && rd_final) begin
                    state_next = PUSH;
                end
            end
            PUSH: begin
                if (!fifo_full) begin
                    state_next = more_bytes ? FETCH : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        busy        = 1'b0;
        push        = 1'b0;
        drain_done  = 1'b0;
        case (state)
            IDLE: ;
            FETCH: begin
                busy      = 1'b1;
                mem_rd_en = (issue_left != 5'd0);
                if (issue_left != 5'd0) begin
                    mem_rd_addr = base_q + ADDR_WIDTH'(byte_idx);
                end
            end
            PUSH: begin
                busy = 1'b1;
                push = !fifo_full;
            end
            DRAIN: begin
                busy = 1'b1;
                // Finish when the FIFO is empty now, or will be after this pop,
                // so done lands in the cycle right after the last acceptance.
                drain_done = fifo_empty || (pop && fifo_count == (PTR_W+1)'(1));
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch / pack datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= '0;
            size_q       <= '0;
            byte_idx     <= '0;
            issue_left   <= '0;
            rd_pend      <= 1'b0;
            rd_final     <= 1'b0;
            rd_lane      <= '0;
            pack_q       <= '0;
            done_q       <= 1'b0;
            words_sent_q <= '0;
        end else begin
            done_q   <= drain_done;
            rd_pend  <= mem_rd_en;
            rd_lane  <= byte_idx[3:0];
            rd_final <= (issue_left == 5'd1);

            if (start_ok) begin
                base_q       <= tile_base_addr;
                size_q       <= tile_size_bytes;
                byte_idx     <= '0;
                issue_left   <= min16(tile_size_bytes);
                words_sent_q <= '0;
            end else if (pop) begin
                words_sent_q <= words_sent_q + (SIZE_WIDTH-4)'(1);
            end

            if (mem_rd_en) begin
                byte_idx   <= byte_idx + SIZE_WIDTH'(1);
                issue_left <= issue_left - 5'd1;
            end

            // Read data returns one cycle after the strobe.
            if (rd_pend) begin
                pack_q[int'(rd_lane)*8 +: 8] <= mem_rd_data;
            end

            // Clearing the pack register gives zero padding in a short last word.
            if (push) begin
                pack_q <= '0;
                if (more_bytes) begin
                    issue_left <= min16(bytes_left);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output word FIFO (bit 128 of each entry is the last flag)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PTR_W-1:0]] <= {!more_bytes, pack_q};
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    assign tile_valid = !fifo_empty;
    assign tile_data  = fifo_empty ? 128'd0 : head[127:0];
    assign tile_last  = !fifo_empty && head[128];
    assign done       = done_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_av2_tile_bitstream_feeder.sv
module tb_av2_tile_bitstream_feeder;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [31:0]  tile_base_addr;
    logic [23:0]  tile_size_bytes;
    logic         mem_rd_en;
    logic [31:0]  mem_rd_addr;
    logic [7:0]   mem_rd_data;
    logic [127:0] tile_data;
    logic         tile_valid;
    logic         tile_ready;
    logic         tile_last;
    logic         busy;
    logic         done;
    logic [19:0]  words_sent;

    int checks = 0;
    int errors = 0;

    logic [31:0]  rd_q[$];
    logic [127:0] word_q[$];
    logic         last_q[$];
    int           done_cnt  = 0;
    int           valid_cnt = 0;

    localparam logic [127:0] W0 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] W1 = 128'h1f1e1d1c1b1a19181716151413121110;
    localparam logic [127:0] W2 = 128'h2f2e2d2c2b2a29282726252423222120;
    localparam logic [127:0] W3 = 128'h3f3e3d3c3b3a39383736353433323130;
    localparam logic [127:0] WP = 128'h13121110;

    `define CHK(tag, obs, exp) \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
        end

    av2_tile_bitstream_feeder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .tile_base_addr  (tile_base_addr),
        .tile_size_bytes (tile_size_bytes),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .tile_data       (tile_data),
        .tile_valid      (tile_valid),
        .tile_ready      (tile_ready),
        .tile_last       (tile_last),
        .busy            (busy),
        .done            (done),
        .words_sent      (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: value = address low byte, returned one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];
        else           mem_rd_data <= 8'ha5;
    end

    // Observer
    always @(negedge clk) begin
        if (mem_rd_en) rd_q.push_back(mem_rd_addr);
        if (tile_valid) valid_cnt++;
        if (tile_valid && tile_ready) begin
            word_q.push_back(tile_data);
            last_q.push_back(tile_last);
        end
        if (done) done_cnt++;
    end

    task automatic clear_obs();
        rd_q.delete();
        word_q.delete();
        last_q.delete();
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [23:0] size);
        @(posedge clk); #1;
        tile_base_addr  = base;
        tile_size_bytes = size;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < max_cycles && done_cnt == d0; i++) @(negedge clk);
        `CHK("done_timeout", (done_cnt > d0), 1'b1)
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_contig(input string tag, input logic [31:0] base);
        int bad;
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i] !== base + i) bad++;
        `CHK(tag, bad, 0)
    endtask

    initial begin
        int rd_en_seen;
        int data_moved;
        logic [127:0] hd;

        rst_n = 1'b0;
        start = 1'b0;
        tile_base_addr  = '0;
        tile_size_bytes = '0;
        tile_ready = 1'b1;
        #23;
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_rd_en", mem_rd_en, 1'b0)
        `CHK("rst_valid", tile_valid, 1'b0)
        `CHK("rst_data", tile_data, 128'd0)
        `CHK("rst_words", words_sent, 20'd0)
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Size 32 at 0x100
        clear_obs();
        do_start(32'h100, 24'd32);
        `CHK("t1_busy", busy, 1'b1)
        wait_done(300);
        `CHK("t1_nreads", rd_q.size(), 32)
        `CHK("t1_first_addr", rd_q[0], 32'h100)
        `CHK("t1_last_addr", rd_q[31], 32'h11f)
        check_contig("t1_contig", 32'h100);
        `CHK("t1_nwords", word_q.size(), 2)
        `CHK("t1_word0", word_q[0], W0)
        `CHK("t1_last0", last_q[0], 1'b0)
        `CHK("t1_word1", word_q[1], W1)
        `CHK("t1_last1", last_q[1], 1'b1)
        `CHK("t1_words_sent", words_sent, 20'd2)
        repeat (10) @(posedge clk); #1;
        `CHK("t1_done_once", done_cnt, 1)
        `CHK("t1_idle", busy, 1'b0)

        // Size 20 at 0: partial last word, zero padding
        clear_obs();
        do_start(32'h0, 24'd20);
        wait_done(300);
        `CHK("t2_nreads", rd_q.size(), 20)
        `CHK("t2_last_addr", rd_q[19], 32'h13)
        `CHK("t2_nwords", word_q.size(), 2)
        `CHK("t2_word0", word_q[0], W0)
        `CHK("t2_word1", word_q[1], WP)
        `CHK("t2_last1", last_q[1], 1'b1)
        `CHK("t2_words_sent", words_sent, 20'd2)

        // Size 64 with backpressure
        clear_obs();
        tile_ready = 1'b0;
        do_start(32'h200, 24'd64);
        repeat (60) @(posedge clk); #1;
        `CHK("t3_reads_stalled", rd_q.size(), 48)
        `CHK("t3_valid", tile_valid, 1'b1)
        `CHK("t3_head", tile_data, W0)
        hd = tile_data;
        rd_en_seen = 0;
        data_moved = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_rd_en) rd_en_seen++;
            if (tile_data !== hd) data_moved++;
        end
        `CHK("t3_no_reads", rd_en_seen, 0)
        `CHK("t3_stable", data_moved, 0)
        `CHK("t3_words_held", words_sent, 20'd0)
        @(posedge clk); #1;
        tile_ready = 1'b1;
        wait_done(300);
        `CHK("t3_nreads", rd_q.size(), 64)
        check_contig("t3_contig", 32'h200);
        `CHK("t3_nwords", word_q.size(), 4)
        `CHK("t3_word0", word_q[0], W0)
        `CHK("t3_word1", word_q[1], W1)
        `CHK("t3_word2", word_q[2], W2)
        `CHK("t3_word3", word_q[3], W3)
        `CHK("t3_last2", last_q[2], 1'b0)
        `CHK("t3_last3", last_q[3], 1'b1)
        `CHK("t3_words_sent", words_sent, 20'd4)
        `CHK("t3_done_once", done_cnt, 1)

        // Size 0: done two cycles after start, nothing else
        clear_obs();
        do_start(32'h50, 24'd0);
        `CHK("t4_done_early", done, 1'b0)
        @(posedge clk); #1;
        `CHK("t4_done", done, 1'b1)
        @(posedge clk); #1;
        `CHK("t4_done_pulse", done, 1'b0)
        `CHK("t4_words_sent", words_sent, 20'd0)
        repeat (5) @(posedge clk); #1;
        `CHK("t4_no_reads", rd_q.size(), 0)
        `CHK("t4_no_valid", valid_cnt, 0)
        `CHK("t4_done_cnt", done_cnt, 1)

        // Second start during a 48-byte transfer is ignored
        clear_obs();
        do_start(32'h300, 24'd48);
        repeat (10) @(posedge clk);
        do_start(32'h999, 24'd5);
        wait_done(300);
        `CHK("t5_nreads", rd_q.size(), 48)
        check_contig("t5_contig", 32'h300);
        `CHK("t5_nwords", word_q.size(), 3)
        `CHK("t5_word2", word_q[2], W2)
        `CHK("t5_last2", last_q[2], 1'b1)
        `CHK("t5_words_sent", words_sent, 20'd3)
        repeat (20) @(posedge clk); #1;
        `CHK("t5_done_once", done_cnt, 1)
        `CHK("t5_idle", busy, 1'b0)

        // Reset during the fetch of word 1
        clear_obs();
        do_start(32'h400, 24'd64);
        repeat (25) @(posedge clk);
        #1;
        `CHK("t6_fetching", mem_rd_en, 1'b1)
        `CHK("t6_one_sent", words_sent, 20'd1)
        #2;
        rst_n = 1'b0;
        #1;
        `CHK("t6_rst_rd_en", mem_rd_en, 1'b0)
        `CHK("t6_rst_addr", mem_rd_addr, 32'h0)
        `CHK("t6_rst_busy", busy, 1'b0)
        `CHK("t6_rst_valid", tile_valid, 1'b0)
        `CHK("t6_rst_data", tile_data, 128'd0)
        `CHK("t6_rst_words", words_sent, 20'd0)
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        `CHK("t6_no_done", done_cnt, 0)
        clear_obs();
        do_start(32'h10, 24'd16);
        wait_done(300);
        `CHK("t6_nreads", rd_q.size(), 16)
        `CHK("t6_nwords", word_q.size(), 1)
        `CHK("t6_word0", word_q[0], W1)
        `CHK("t6_last0", last_q[0], 1'b1)
        `CHK("t6_words_sent", words_sent, 20'd1)
        `CHK("t6_done_once", done_cnt, 1)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/av2_tile_bitstream_feeder.md
Name: av2_tile_bitstream_feeder

Overview:
- Source end of the tile bitstream interface: fetches a tile's compressed bytes from byte-wide bitstream memory, packs them into 128-bit words and drives them on the tile_data/tile_valid/tile_ready handshake into the tile decoder.
- Sits between the bitstream buffer and av2_tile_decoder_real_fixed.
- Tells the decoder side when the last word of the tile has been sent.

Parameters:
- ADDR_WIDTH, 32, bitstream memory byte address width.
- SIZE_WIDTH, 24, width of the tile byte count.
- FIFO_DEPTH, 2, output word FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latch tile_base_addr/tile_size_bytes and begin
- tile_base_addr  in  ADDR_WIDTH  byte address of first tile byte
- tile_size_bytes  in  SIZE_WIDTH  tile length in bytes
- mem_rd_en  out  1  byte read strobe
- mem_rd_addr  out  ADDR_WIDTH  byte read address
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
- tile_data  out  128  packed word; byte k occupies bits [8k+7:8k]
- tile_valid  out  1  word valid
- tile_ready  in  1  decoder accepts word when valid&ready
- tile_last  out  1  qualifies the final word of the tile (with tile_valid)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word has been accepted
- words_sent  out  SIZE_WIDTH-4  count of accepted words in the current tile

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM IDLE; FIFO empty; pack register zero; counters 0.
- FSM states and transitions:
  - IDLE: on start, latch address/size, clear words_sent.
    - size==0: go DRAIN.
    - otherwise: go FETCH.
  - FETCH: issue one read per cycle, mem_rd_addr = base + byte_index, for min(16, bytes_remaining) cycles. Each returned byte is written into lane (byte_index mod 16) of the pack register one cycle later. After the final byte of the word is captured, go PUSH.
  - PUSH: wait here while the FIFO is full; mem_rd_en=0 in this state.
    - When not full, push the pack register plus a last flag (set when bytes_remaining reaches 0), then clear the pack register.
    - If bytes remain, go FETCH; else go DRAIN.
  - DRAIN: wait for the FIFO to empty, then assert done for one cycle and go IDLE.
- Padding: unused lanes of a partial final word are 0. Word count = ceil(size/16).
- Output handshake:
  - tile_valid = FIFO non-empty; tile_data and tile_last come from the FIFO head.
  - Head is stable while valid&!ready. Pop on valid&ready.
  - A push and a pop in the same cycle on a full FIFO is not allowed: PUSH waits for !full.
  - Pop on the last word with an empty FIFO afterwards: done in the next cycle.
- words_sent increments on each valid&ready and holds its value after done until the next start.
- start while busy is ignored; latched parameters are unchanged.
- done and start in the same cycle: start is accepted, since the FSM is in IDLE the following cycle.
- Reset mid-operation: everything clears immediately; a pending word is discarded and no done is issued.
- No read is issued while in PUSH/DRAIN/IDLE. Reads are never issued beyond base+size-1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Size 32, base 0x100, memory byte value = addr[7:0], ready=1: exactly 32 reads, addresses 0x100..0x11F. Word0 = 0x0F0E..0100; word1 = 0x1F1E..1110 with tile_last=1. done pulses once, words_sent=2.
- Size 20, base 0: 2 words. Word1 has bytes 0x10..0x13 in bits [31:0], bits [127:32]=0, tile_last=1.
- Size 64 with ready=0 for 100 cycles: FIFO holds 2 words, FSM stalls in PUSH, mem_rd_en stays 0. tile_data is stable throughout. Raising ready delivers all 4 words in order.
- Size 0: no mem_rd_en and no tile_valid; done pulses 2 cycles after start; words_sent=0.
- Second start pulse during a 48-byte transfer: ignored. Exactly 3 words and one done.
- rst_n low during word 1 fetch: all outputs 0 asynchronously. A fresh start with size 16 then produces a single correct word with tile_last=1.
